uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter between N_REQ byte producers using round-robin arbitration.
- Accepts one byte plus frame mode per grant over a valid/ready handshake.
- Drives the transmitter's DATA / MODE / DATA_AVAILABLE inputs, tracks its BUSY output, and holds DATA and MODE stable for the whole frame.
- Sits between the system's message sources (command responder, debug logger, status reporter) and the tx block.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_if.sv | 34 +++
 rtl/rr_pick.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path.
//   MODE_*      : frame-mode encodings understood by the transmitter
//   arb_state_e : state encoding of the transmit arbiter
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam logic [1:0] MODE_8N1 = 2'b00;
  localparam logic [1:0] MODE_8E1 = 2'b01;
  localparam logic [1:0] MODE_8O1 = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_HOLD   = 2'd2,
    S_GAP    = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester handshake and the transmitter launch interface.
//   req_valid / req_data / req_mode / req_ready : producers -> arbiter
//   tx_data / tx_mode / tx_data_available       : arbiter -> transmitter
//   tx_busy                                     : transmitter -> arbiter
// Modports:
//   master : environment side (producers + transmitter)
//   slave  : the arbiter
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [2*N_REQ-1:0] req_mode;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         tx_data;
  logic [1:0]         tx_mode;
  logic               tx_data_available;
  logic               tx_busy;

  modport master (
    output req_valid, req_data, req_mode, tx_busy,
    input  req_ready, tx_data, tx_mode, tx_data_available
  );

  modport slave (
    input  req_valid, req_data, req_mode, tx_busy,
    output req_ready, tx_data, tx_mode, tx_data_available
  );

endinterface

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches the request vector starting
// at (i_last + 1) mod N, wrapping, and reports the first set index.
//   i_req   : request vector
//   i_last  : index granted last time
//   o_found : at least one request is set
//   o_idx   : selected index (0 when nothing is found)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  logic [W-1:0] w_probe;

  // NOTE: every signal written in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_probe = '0;
    // Offset k=N lands back on i_last itself, so the last winner is
    // considered only after everybody else.
    for (int k = 1; k <= N; k++) begin
      w_probe = W'((int'(i_last) + k) % N);
      if (!o_found && i_req[w_probe]) begin
        o_found = 1'b1;
        o_idx   = w_probe;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between N_REQ byte producers, round-robin.
// One byte + frame mode is accepted per grant; DATA/MODE are held stable
// from the grant until the transmitter drops BUSY.
// Ports:
//   i_clk         : clock, rising edge
//   i_rst         : synchronous active-high reset
//   bus           : requester handshake + transmitter launch (slave side)
//   o_grant_id    : index of the current or last granted requester
//   o_active      : high whenever the FSM is not idle
//   o_timeout_err : one-cycle pulse when a launch is abandoned
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ          = 4,
  parameter  int LAUNCH_TIMEOUT = 64,
  parameter  int GAP_CYCLES     = 0,
  localparam int GW             = $clog2(N_REQ)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  uart_tx_arbiter_if.slave bus,
  output logic [GW-1:0]   o_grant_id,
  output logic            o_active,
  output logic            o_timeout_err
);

  localparam int TO_W = (LAUNCH_TIMEOUT > 2) ? $clog2(LAUNCH_TIMEOUT) : 1;
  localparam int GP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(LAUNCH_TIMEOUT - 1);
  localparam logic [GP_W-1:0] GAP_LAST   = GP_W'(GAP_CYCLES - 1);
  // Reset pointer to the top index so requester 0 wins the first search.
  localparam logic [GW-1:0]   GRANT_INIT = GW'(N_REQ - 1);

  arb_state_e      r_state;
  logic [7:0]      r_tx_data;
  logic [1:0]      r_tx_mode;
  logic [GW-1:0]   r_grant_id;
  logic            r_timeout_err;
  logic [TO_W-1:0] r_to_cnt;
  logic [GP_W-1:0] r_gap_cnt;

  arb_state_e      w_state_next;
  logic [TO_W-1:0] w_to_cnt_next;
  logic [GP_W-1:0] w_gap_cnt_next;
  logic            w_timeout_next;
  logic            w_grant;
  logic            w_found;
  logic [GW-1:0]   w_sel;
  logic [N_REQ-1:0] w_ready;

  rr_pick #(.N(N_REQ)) u_rr_pick (
    .i_req   (bus.req_valid),
    .i_last  (r_grant_id),
    .o_found (w_found),
    .o_idx   (w_sel)
  );

  // Next-state and counter logic.
  always_comb begin
    w_state_next   = r_state;
    w_to_cnt_next  = r_to_cnt;
    w_gap_cnt_next = r_gap_cnt;
    w_timeout_next = 1'b0;
    w_grant        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // A busy transmitter here is a foreign or leftover frame: wait it out.
        if (!bus.tx_busy && w_found) begin
          w_grant       = 1'b1;
          w_state_next  = S_LAUNCH;
          w_to_cnt_next = '0;
        end
      end
      S_LAUNCH: begin
        if (bus.tx_busy) begin
          w_state_next  = S_HOLD;
          w_to_cnt_next = '0;
        end else if (r_to_cnt == TO_LAST) begin
          // Abandon the byte; the pointer stays on this requester so the
          // next search starts after it.
          w_state_next   = S_IDLE;
          w_timeout_next = 1'b1;
          w_to_cnt_next  = '0;
        end else begin
          w_to_cnt_next = r_to_cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (!bus.tx_busy) begin
          if (GAP_CYCLES > 0) begin
            w_state_next   = S_GAP;
            w_gap_cnt_next = '0;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_next   = S_IDLE;
          w_gap_cnt_next = '0;
        end else begin
          w_gap_cnt_next = r_gap_cnt + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Accept pulse is combinational so the transfer completes in the idle cycle.
  always_comb begin
    w_ready = '0;
    if (w_grant) w_ready[w_sel] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_tx_data     <= '0;
      r_tx_mode     <= MODE_8N1;
      r_grant_id    <= GRANT_INIT;
      r_timeout_err <= 1'b0;
      r_to_cnt      <= '0;
      r_gap_cnt     <= '0;
    end else begin
      r_state       <= w_state_next;
      r_timeout_err <= w_timeout_next;
      r_to_cnt      <= w_to_cnt_next;
      r_gap_cnt     <= w_gap_cnt_next;
      // DATA/MODE change only on a grant, which keeps them frozen for the
      // whole launch and hold phase.
      if (w_grant) begin
        r_tx_data  <= bus.req_data[{w_sel, 3'b000} +: 8];
        r_tx_mode  <= bus.req_mode[{w_sel, 1'b0} +: 2];
        r_grant_id <= w_sel;
      end
    end
  end

  assign bus.req_ready         = w_ready;
  assign bus.tx_data           = r_tx_data;
  assign bus.tx_mode           = r_tx_mode;
  assign bus.tx_data_available = (r_state == S_LAUNCH);
  assign o_grant_id            = r_grant_id;
  assign o_active              = (r_state != S_IDLE);
  assign o_timeout_err         = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (N_REQ=4, LAUNCH_TIMEOUT=16,
// GAP_CYCLES=3). The bench plays producers and transmitter.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N_REQ = 4;
  localparam int LT    = 16;
  localparam int GAP   = 3;

  logic       clk;
  logic       rst;
  logic [1:0] grant_id;
  logic       active;
  logic       timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

  uart_tx_arbiter #(
    .N_REQ          (N_REQ),
    .LAUNCH_TIMEOUT (LT),
    .GAP_CYCLES     (GAP)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .bus           (bus.slave),
    .o_grant_id    (grant_id),
    .o_active      (active),
    .o_timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling happens 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Transmitter model: wait for a launch, raise BUSY, hold it four cycles
  // while checking that DATA/MODE stay put, then release BUSY.
  task automatic tx_frame(input logic [7:0] exp_data, input logic [1:0] exp_mode,
                          input logic [1:0] exp_id);
    int n;
    n = 0;
    while (!bus.tx_data_available && n < 50) begin
      tick();
      n++;
    end
    check("launch_seen", 32'(bus.tx_data_available), 1);
    check("frame_data", 32'(bus.tx_data), 32'(exp_data));
    check("frame_grant_id", 32'(grant_id), 32'(exp_id));
    bus.tx_busy = 1'b1;
    tick();
    check("hold_da_low", 32'(bus.tx_data_available), 0);
    repeat (4) begin
      check("hold_data", 32'(bus.tx_data), 32'(exp_data));
      check("hold_mode", 32'(bus.tx_mode), 32'(exp_mode));
      tick();
    end
    bus.tx_busy = 1'b0;
  endtask

  logic [7:0] rr_data [5];
  logic [1:0] rr_id   [5];

  initial begin
    rr_data = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};
    rr_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // ---- Reset state ----
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_mode  = '0;
    bus.tx_busy   = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(bus.req_ready), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    check("rst_tx_mode", 32'(bus.tx_mode), 0);
    check("rst_da", 32'(bus.tx_data_available), 0);
    check("rst_grant_id", 32'(grant_id), 3);
    check("rst_active", 32'(active), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    rst = 1'b0;

    // ---- Single byte from requester 0 ----
    bus.req_valid = 4'b0001;
    bus.req_data  = 32'h0000_00A5;
    bus.req_mode  = {4{MODE_8N1}};
    #1;
    check("t1_ready", 32'(bus.req_ready), 32'h1);
    check("t1_da_not_with_ready", 32'(bus.tx_data_available), 0);
    tick();
    bus.req_valid = '0;
    check("t1_ready_pulse_end", 32'(bus.req_ready), 0);
    check("t1_da_rise", 32'(bus.tx_data_available), 1);
    check("t1_tx_data", 32'(bus.tx_data), 32'hA5);
    check("t1_tx_mode", 32'(bus.tx_mode), 0);
    check("t1_grant_id", 32'(grant_id), 0);
    tick();
    tick();
    check("t1_da_held", 32'(bus.tx_data_available), 1);
    bus.tx_busy = 1'b1;
    tick();
    check("t1_da_fall", 32'(bus.tx_data_available), 0);
    tick();
    tick();
    check("t1_hold_data", 32'(bus.tx_data), 32'hA5);
    bus.tx_busy = 1'b0;
    tick();
    tick();
    tick();
    check("t1_gap_active", 32'(active), 1);
    tick();
    check("t1_back_idle", 32'(active), 0);

    // ---- Round robin with all four valid, after fresh reset ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'h4030_2010;
    for (int k = 0; k < 5; k++) tx_frame(rr_data[k], MODE_8N1, rr_id[k]);
    bus.req_valid = '0;
    repeat (6) tick();
    check("t2_idle", 32'(active), 0);

    // ---- Skip idle requester 1, grant 2 with 8E1 ----
    bus.req_valid = 4'b0100;
    bus.req_data  = 32'h0003_0000;
    bus.req_mode  = {MODE_8N1, MODE_8E1, MODE_8N1, MODE_8N1};
    #1;
    check("t3_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    tx_frame(8'h03, MODE_8E1, 2'd2);
    repeat (6) tick();

    // ---- Launch timeout: transmitter never goes busy ----
    bus.req_valid = 4'b1000;
    bus.req_data  = 32'h7700_0000;
    bus.req_mode  = {4{MODE_8N1}};
    #1;
    check("t4_ready", 32'(bus.req_ready), 32'h8);
    tick();
    bus.req_valid = '0;
    check("t4_da_launch", 32'(bus.tx_data_available), 1);
    check("t4_grant_id", 32'(grant_id), 3);
    for (int j = 1; j < LT; j++) begin
      tick();
      check("t4_da_waiting", 32'(bus.tx_data_available), 1);
      check("t4_no_early_timeout", 32'(timeout_err), 0);
    end
    tick();
    check("t4_timeout_pulse", 32'(timeout_err), 1);
    check("t4_da_dropped", 32'(bus.tx_data_available), 0);
    check("t4_idle", 32'(active), 0);
    tick();
    check("t4_pulse_one_cycle", 32'(timeout_err), 0);
    bus.req_valid = 4'b0001;
    bus.req_data  = 32'h0000_005A;
    #1;
    check("t4_next_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    tx_frame(8'h5A, MODE_8N1, 2'd0);
    repeat (6) tick();

    // ---- BUSY held in idle blocks grants; gap of 3 cycles ----
    bus.req_data  = 32'h4030_2010;
    bus.tx_busy   = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    check("t5_busy_no_ready", 32'(bus.req_ready), 0);
    repeat (3) begin
      tick();
      check("t5_busy_still_no_ready", 32'(bus.req_ready), 0);
      check("t5_busy_idle", 32'(active), 0);
    end
    bus.tx_busy = 1'b0;
    #1;
    check("t5_ready_after_busy", 32'(bus.req_ready), 32'h2);
    tick();
    check("t5_launch", 32'(bus.tx_data_available), 1);
    check("t5_grant_id", 32'(grant_id), 1);
    bus.tx_busy = 1'b1;
    tick();
    bus.tx_busy = 1'b0;
    for (int g = 0; g < GAP; g++) begin
      tick();
      check("t5_gap_no_ready", 32'(bus.req_ready), 0);
    end
    tick();
    check("t5_ready_after_gap", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    check("t5_grant2", 32'(grant_id), 2);
    bus.tx_busy = 1'b1;
    tick();
    check("t6_in_hold", 32'(active), 1);
    check("t6_hold_data", 32'(bus.tx_data), 32'h30);

    // ---- Reset during hold ----
    rst = 1'b1;
    tick();
    check("t6_rst_tx_data", 32'(bus.tx_data), 0);
    check("t6_rst_tx_mode", 32'(bus.tx_mode), 0);
    check("t6_rst_da", 32'(bus.tx_data_available), 0);
    check("t6_rst_grant_id", 32'(grant_id), 3);
    check("t6_rst_active", 32'(active), 0);
    check("t6_rst_timeout", 32'(timeout_err), 0);
    check("t6_rst_ready", 32'(bus.req_ready), 0);
    rst           = 1'b0;
    bus.tx_busy   = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    check("t6_first_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    check("t6_first_grant", 32'(grant_id), 0);
    check("t6_first_data", 32'(bus.tx_data), 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
